// File: rtl/e15_prog_loader.sv
// Program loader for the E15 processor: clears a 16-word program memory, accepts a
// valid/ready stream of instruction words, then serves fetches while the CPU runs.
module e15_prog_loader #(
  parameter int WORD_W = 12,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [WORD_W-1:0] ld_word,
  input  logic              ld_last,
  input  logic              restart,
  input  logic [3:0]        pc,
  output logic [WORD_W-1:0] instr,
  output logic              cpu_run,
  output logic              load_done,
  output logic [4:0]        word_count,
  output logic              err_overflow
);

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_e;

  state_e            state_q, state_d;
  logic [3:0]        clr_ptr_q, clr_ptr_d;
  logic [3:0]        wr_ptr_q, wr_ptr_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              run_q, run_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              xfer;
  logic              mem_we;
  logic [3:0]        mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = clr_ptr_q;
    mem_wdata = '0;
    xfer      = (state_q == LOAD) && ld_valid;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 4'd1;
        if (clr_ptr_q == 4'(DEPTH - 1)) state_d = LOAD;
      end
      LOAD: begin
        if (xfer) begin
          mem_we    = 1'b1;
          mem_addr  = wr_ptr_q;
          mem_wdata = ld_word;
          wr_ptr_d  = wr_ptr_q + 4'd1;
          cnt_d     = cnt_q + 5'd1;
          // The 16th word ends the load even without ld_last; flag it as overflow.
          if (ld_last) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else if (cnt_q == 5'(DEPTH - 1)) begin
            state_d = RUN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (restart) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
          wr_ptr_d  = '0;
          cnt_d     = '0;
          err_d     = 1'b0;
        end
      end
      default: state_d = CLEAR;
    endcase
    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      run_q     <= run_d;
      done_q    <= done_d;
    end
  end

  // Memory has no reset; CLEAR rewrites every location before the CPU can fetch.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  assign ld_ready     = (state_q == LOAD);
  assign instr        = (state_q == RUN) ? mem_q[pc] : '0;
  assign cpu_run      = run_q;
  assign load_done    = done_q;
  assign word_count   = cnt_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_e15_prog_loader.sv
// Self-checking bench for e15_prog_loader against a per-transaction program-load model.
module tb_e15_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [11:0] ld_word;
  logic        ld_last;
  logic        restart;
  logic [3:0]  pc;
  logic [11:0] instr;
  logic        cpu_run;
  logic        load_done;
  logic [4:0]  word_count;
  logic        err_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: phase of the loader and the program image it should hold.
  bit          m_run;
  int          m_clear_left;
  int          m_count;
  bit          m_err;
  bit          m_done;
  logic [11:0] m_mem [16];

  e15_prog_loader #(.WORD_W(12), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_word(ld_word), .ld_last(ld_last), .restart(restart), .pc(pc),
    .instr(instr), .cpu_run(cpu_run), .load_done(load_done),
    .word_count(word_count), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 0; m_clear_left = 16; m_count = 0; m_err = 0; m_done = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven, then clock the DUT.
  task automatic tick();
    m_done = 0;
    if (m_run) begin
      if (restart) begin
        m_run = 0; m_clear_left = 16; m_count = 0; m_err = 0;
      end
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0) for (int i = 0; i < 16; i++) m_mem[i] = '0;
    end else if (ld_valid) begin
      m_mem[m_count] = ld_word;
      m_count++;
      if (ld_last || m_count == 16) begin
        m_run = 1; m_done = 1; m_err = !ld_last;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ld_ready !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++; $display("FAIL wait_ready: ld_ready=%b after %0d cycles, need 1", ld_ready, n);
    end
  endtask

  task automatic go_load();
    restart = 1; tick(); restart = 0;
    wait_ready();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({ld_ready, cpu_run, load_done, err_overflow, word_count, instr} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: rdy=%b run=%b done=%b err=%b cnt=%0d instr=%h, need all 0",
                 ld_ready, cpu_run, load_done, err_overflow, word_count, instr);
      end
      #4;
    end
  endtask

  task automatic test_clear_window();
    @(posedge clk); #1;
    rst = 0; model_reset();
    ld_valid = 1; ld_word = 12'hABC; ld_last = 0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ld_ready !== 1'b0 || word_count !== 5'd0) begin
        errors++; $display("FAIL clear_window c%0d: rdy=%b cnt=%0d, need 0/0", i, ld_ready, word_count);
      end
      tick();
    end
    ld_valid = 0;
    checks++;
    if (ld_ready !== 1'b1 || word_count !== 5'd0) begin
      errors++; $display("FAIL clear_end: rdy=%b cnt=%0d, need 1/0", ld_ready, word_count);
    end
  endtask

  task automatic test_basic_load();
    logic [11:0] w [3];
    w[0] = 12'h905; w[1] = 12'hB11; w[2] = 12'h000;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1; ld_word = w[k]; ld_last = (k == 2); tick();
    end
    ld_valid = 0; ld_last = 0;
    checks++;
    if (cpu_run !== 1'b1 || load_done !== 1'b1 || word_count !== 5'd3 || ld_ready !== 1'b0) begin
      errors++; $display("FAIL basic_enter_run: run=%b done=%b cnt=%0d rdy=%b, need 1/1/3/0",
                         cpu_run, load_done, word_count, ld_ready);
    end
    tick();
    checks++;
    if (load_done !== 1'b0 || word_count !== 5'd3 || cpu_run !== 1'b1) begin
      errors++; $display("FAIL basic_done_pulse: done=%b cnt=%0d run=%b, need 0/3/1",
                         load_done, word_count, cpu_run);
    end
    for (int p = 0; p < 16; p++) begin
      pc = 4'(p); #1;
      checks++;
      if (instr !== ((p < 3) ? w[p] : 12'h000)) begin
        errors++; $display("FAIL basic_fetch pc=%0d: instr=%h need %h", p, instr, (p < 3) ? w[p] : 12'h000);
      end
    end
    pc = 0;
  endtask

  task automatic test_restart();
    logic [11:0] w;
    restart = 1; tick(); restart = 0;
    checks++;
    if (cpu_run !== 1'b0 || err_overflow !== 1'b0 || word_count !== 5'd0 || instr !== 12'h000 || ld_ready !== 1'b0) begin
      errors++; $display("FAIL restart_clear: run=%b err=%b cnt=%0d instr=%h rdy=%b, need 0/0/0/000/0",
                         cpu_run, err_overflow, word_count, instr, ld_ready);
    end
    wait_ready();
    w = 12'(($urandom % 4095) + 1);
    ld_valid = 1; ld_word = w; ld_last = 1; tick();
    ld_valid = 0; ld_last = 0;
    checks++;
    if (cpu_run !== 1'b1 || word_count !== 5'd1) begin
      errors++; $display("FAIL restart_reload: run=%b cnt=%0d, need 1/1", cpu_run, word_count);
    end
    for (int p = 0; p < 16; p++) begin
      pc = 4'(p); #1;
      checks++;
      if (instr !== ((p == 0) ? w : 12'h000)) begin
        errors++; $display("FAIL restart_fetch pc=%0d: instr=%h need %h", p, instr, (p == 0) ? w : 12'h000);
      end
    end
    pc = 0;
  endtask

  task automatic test_random_valid();
    logic [11:0] w [5];
    int acc = 0;
    int cyc = 0;
    go_load();
    for (int k = 0; k < 5; k++) w[k] = 12'($urandom);
    while (acc < 5 && cyc < 200) begin
      ld_valid = 1'($urandom_range(0, 1));
      restart  = 1'($urandom_range(0, 1));
      if (ld_valid) begin
        ld_word = w[acc]; ld_last = (acc == 4); acc++;
      end else begin
        ld_word = 12'($urandom); ld_last = 1'($urandom_range(0, 1));
      end
      checks++;
      if (ld_ready !== 1'b1) begin
        errors++; $display("FAIL random_ready c%0d: rdy=%b need 1", cyc, ld_ready);
      end
      tick(); cyc++;
    end
    ld_valid = 0; restart = 0; ld_last = 0;
    checks++;
    if (acc != 5 || cpu_run !== 1'b1 || load_done !== m_done || word_count !== 5'(m_count) || m_count != 5) begin
      errors++; $display("FAIL random_done: acc=%0d run=%b done=%b cnt=%0d, need 5/1/1/5",
                         acc, cpu_run, load_done, word_count);
    end
    for (int p = 0; p < 16; p++) begin
      pc = 4'(p); #1;
      checks++;
      if (instr !== ((p < 5) ? w[p] : 12'h000) || instr !== m_mem[p]) begin
        errors++; $display("FAIL random_fetch pc=%0d: instr=%h need %h", p, instr, (p < 5) ? w[p] : 12'h000);
      end
    end
    pc = 0;
  endtask

  task automatic test_overflow();
    logic [11:0] w [17];
    go_load();
    for (int k = 0; k < 17; k++) w[k] = 12'(($urandom % 4095) + 1);
    for (int k = 0; k < 17; k++) begin
      ld_valid = 1; ld_word = w[k]; ld_last = 0;
      checks++;
      if (ld_ready !== (k < 16)) begin
        errors++; $display("FAIL overflow_ready w%0d: rdy=%b need %b", k, ld_ready, k < 16);
      end
      tick();
    end
    ld_valid = 0;
    checks++;
    if (err_overflow !== 1'b1 || cpu_run !== 1'b1 || ld_ready !== 1'b0 || word_count !== 5'd16 || load_done !== 1'b0) begin
      errors++; $display("FAIL overflow_state: err=%b run=%b rdy=%b cnt=%0d done=%b, need 1/1/0/16/0",
                         err_overflow, cpu_run, ld_ready, word_count, load_done);
    end
    for (int p = 0; p < 16; p++) begin
      pc = 4'(p); #1;
      checks++;
      if (instr !== w[p]) begin
        errors++; $display("FAIL overflow_fetch pc=%0d: instr=%h need %h", p, instr, w[p]);
      end
    end
    pc = 0;
  endtask

  task automatic test_reset_mid_run_and_load();
    logic [11:0] w;
    rst = 1; #1;
    checks++;
    if ({ld_ready, cpu_run, load_done, err_overflow, word_count, instr} !== '0) begin
      errors++; $display("FAIL reset_mid_run: rdy=%b run=%b done=%b err=%b cnt=%0d instr=%h, need all 0",
                         ld_ready, cpu_run, load_done, err_overflow, word_count, instr);
    end
    @(posedge clk); #1; rst = 0; model_reset();
    wait_ready();
    for (int k = 0; k < 2; k++) begin
      ld_valid = 1; ld_word = 12'(($urandom % 4095) + 1); ld_last = 0; tick();
    end
    ld_valid = 0;
    checks++;
    if (word_count !== 5'd2) begin
      errors++; $display("FAIL partial_count: cnt=%0d need 2", word_count);
    end
    #2; rst = 1; #1;
    checks++;
    if ({ld_ready, cpu_run, load_done, err_overflow, word_count, instr} !== '0) begin
      errors++; $display("FAIL reset_mid_load: rdy=%b run=%b done=%b err=%b cnt=%0d instr=%h, need all 0",
                         ld_ready, cpu_run, load_done, err_overflow, word_count, instr);
    end
    @(posedge clk); #1; rst = 0; model_reset();
    wait_ready();
    w = 12'(($urandom % 4095) + 1);
    ld_valid = 1; ld_word = w; ld_last = 1; tick();
    ld_valid = 0; ld_last = 0;
    checks++;
    if (word_count !== 5'd1 || cpu_run !== 1'b1 || load_done !== 1'b1) begin
      errors++; $display("FAIL reload_after_reset: cnt=%0d run=%b done=%b, need 1/1/1", word_count, cpu_run, load_done);
    end
    for (int p = 0; p < 16; p++) begin
      pc = 4'(p); #1;
      checks++;
      if (instr !== ((p == 0) ? w : 12'h000)) begin
        errors++; $display("FAIL reset_fetch pc=%0d: instr=%h need %h", p, instr, (p == 0) ? w : 12'h000);
      end
    end
    pc = 0;
  endtask

  initial begin
    rst = 1; ld_valid = 1; ld_word = 12'h5A5; ld_last = 1; restart = 1; pc = 0;
    model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    test_reset();
    ld_last = 0; restart = 0;
    test_clear_window();
    test_basic_load();
    test_restart();
    test_random_valid();
    test_overflow();
    test_reset_mid_run_and_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e15_prog_loader.md
E15_PROG_LOADER -- requirements
Module: e15_prog_loader

Interface
REQ-001 Parameter WORD_W, 12, instruction width (4 opcode, 2 src, 2 dst, 4 imm); fixed.
REQ-002 Parameter DEPTH, 16, program memory words, addressed by the 4-bit pc; fixed.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ld_valid  input  1  loader word valid.
REQ-006 ld_ready  output  1  loader can accept a word this cycle.
REQ-007 ld_word  input  12  instruction word to store.
REQ-008 ld_last  input  1  qualifies ld_word as the final program word.
REQ-009 restart  input  1  request a reload; honoured only in RUN.
REQ-010 pc  input  4  fetch address from the E15 processor.
REQ-011 instr  output  12  instruction returned for pc.
REQ-012 cpu_run  output  1  processor enable; high only in RUN.
REQ-013 load_done  output  1  one-cycle pulse on the first RUN cycle.
REQ-014 word_count  output  5  words accepted in the current load, 0..16.
REQ-015 err_overflow  output  1  sticky: 16 words accepted without ld_last.

Function
REQ-016 The FSM SHALL have three states: CLEAR, LOAD, RUN.
REQ-017 CLEAR SHALL write 12'h000 (jmp +0, a self-loop halt) to mem[clr_ptr] each cycle, clr_ptr 0..15, then go to LOAD after exactly 16 cycles.
REQ-018 ld_ready SHALL be 1 only in LOAD; 0 in CLEAR and RUN.
REQ-019 A transfer SHALL occur only on a cycle with ld_valid=1 and ld_ready=1; it writes ld_word to mem[wr_ptr] and increments wr_ptr and word_count.
REQ-020 ld_word/ld_last SHALL be ignored when no transfer occurs; ld_valid may remain high across cycles without duplication.
REQ-021 A transfer with ld_last=1 SHALL move LOAD to RUN on the next edge.
REQ-022 A transfer of the 16th word with ld_last=0 SHALL set err_overflow and move to RUN; no word beyond 16 is ever accepted.
REQ-023 Locations not written during LOAD SHALL hold 12'h000 from CLEAR.
REQ-024 In RUN, instr SHALL equal mem[pc] combinationally, with zero-cycle latency from pc; outside RUN, instr SHALL be 12'h000.
REQ-025 cpu_run SHALL be registered and equal 1 exactly in RUN.
REQ-026 load_done SHALL be 1 for exactly the first cycle in RUN after each load.
REQ-027 restart=1 in RUN SHALL move to CLEAR on the next edge; restart SHALL be ignored in CLEAR and LOAD.
REQ-028 Entry to CLEAR SHALL zero wr_ptr, word_count and err_overflow.
REQ-029 word_count SHALL hold its final value throughout RUN.
REQ-030 Memory contents SHALL be modified only in CLEAR and by LOAD transfers; they are never modified in RUN.

Reset
REQ-031 While rst=1, regardless of clk: state=CLEAR, clr_ptr=0, wr_ptr=0, word_count=0, err_overflow=0, cpu_run=0, load_done=0, ld_ready=0, instr=12'h000.
REQ-032 After rst deasserts, CLEAR SHALL run its full 16 cycles; reset asserted mid-LOAD or mid-RUN discards the partial load.

Verification
REQ-033 Release rst, hold ld_valid=1 -> ld_ready=0 for exactly 16 cycles, then 1; no word accepted before then.
REQ-034 Load 3 words 12'h9_05 (movi), 12'hB_11, 12'h000 with ld_last on the third -> cpu_run=1 and load_done pulses once; word_count=3; pc=0..2 returns those words; pc=3..15 returns 12'h000.
REQ-035 Toggle ld_valid randomly while streaming 5 words -> exactly 5 stored, in order, with word_count=5.
REQ-036 Send 17 words with ld_last=0 -> 16 accepted, err_overflow=1, cpu_run=1, ld_ready=0; 17th word never written.
REQ-037 In RUN, pulse restart -> CLEAR, err_overflow=0, word_count=0, instr=12'h000; after reload of 1 word, mem[1..15]=12'h000.
REQ-038 Assert rst after 2 words of a load -> all outputs at reset values immediately; the next load starts at address 0.
